// File: rtl/csw_recorder.sv
// csw_recorder: captures ULA MIC pulses as CSW v1 RLE bytes and streams them to the SDRAM tape area.
//   clk_sys, reset_n        system clock, asynchronous active-low reset
//   ce                      CPU T-state enable; all pulse timing counts ce cycles
//   mic_in, rec_en          MIC level to record, recording enable (level)
//   max_size                buffer capacity in bytes
//   buff_wr/addr/dout/ack   byte write request port, held until buff_ack
//   rec_size, overflow      bytes committed so far, sticky drop/full flag
//   active, done            recording or flushing, one-cycle flush-complete pulse
module csw_recorder #(
   parameter int DIV        = 80,
   parameter int ADDR_W     = 22,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ce,
   input  logic              mic_in,
   input  logic              rec_en,
   input  logic [ADDR_W-1:0] max_size,
   output logic              buff_wr,
   output logic [ADDR_W-1:0] buff_addr,
   output logic [7:0]        buff_dout,
   input  logic              buff_ack,
   output logic [ADDR_W-1:0] rec_size,
   output logic              overflow,
   output logic              active,
   output logic              done
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int FW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ARM, REC, FLUSH} state_t;

   state_t            state_q, state_d;
   logic              rec_en_q;
   logic              level_q, level_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [31:0]       cnt_q, cnt_d, cnt_inc;
   logic              pend_v_q, pend_v_d;
   logic [31:0]       pend_q, pend_d;
   logic              enc_v_q, enc_v_d;
   logic [31:0]       enc_val_q, enc_val_d;
   logic [2:0]        enc_idx_q, enc_idx_d;
   logic [FW:0]       wp_q, wp_d, rp_q, rp_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d, size_q, size_d;
   logic [7:0]        dout_q, dout_d;
   logic              ovf_q, ovf_d, done_q, done_d;
   logic              wrap, edge_seen, new_pulse, enc_long, enc_last, enc_load;
   logic              push, pop, ack, fifo_empty, fifo_full;
   logic [31:0]       new_len;
   logic [7:0]        enc_byte;

   assign wrap       = presc_q == PW'(DIV - 1);
   assign cnt_inc    = (wrap && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
   assign edge_seen  = ce && (mic_in != level_q);
   // Lengths above 255 use the escape form: 00 followed by L little-endian.
   assign enc_long   = |enc_val_q[31:8];
   assign enc_last   = !enc_long || enc_idx_q == 3'd4;
   assign enc_byte   = !enc_long          ? enc_val_q[7:0]   :
                       enc_idx_q == 3'd1  ? enc_val_q[7:0]   :
                       enc_idx_q == 3'd2  ? enc_val_q[15:8]  :
                       enc_idx_q == 3'd3  ? enc_val_q[23:16] :
                       enc_idx_q == 3'd4  ? enc_val_q[31:24] : 8'h00;
   assign fifo_empty = wp_q == rp_q;
   assign fifo_full  = (wp_q[FW] != rp_q[FW]) && (wp_q[FW-1:0] == rp_q[FW-1:0]);
   assign push       = enc_v_q && !fifo_full;
   assign enc_load   = pend_v_q && !enc_v_q;
   assign pop        = !fifo_empty && !wr_q;
   assign ack        = buff_ack && wr_q;

   assign buff_wr    = wr_q;
   assign buff_addr  = addr_q;
   assign buff_dout  = dout_q;
   assign rec_size   = size_q;
   assign overflow   = ovf_q;
   assign done       = done_q;
   assign active     = state_q != IDLE;

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      presc_d   = presc_q;
      cnt_d     = cnt_q;
      pend_v_d  = pend_v_q;
      pend_d    = pend_q;
      enc_v_d   = enc_v_q;
      enc_val_d = enc_val_q;
      enc_idx_d = enc_idx_q;
      wp_d      = wp_q;
      rp_d      = rp_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      dout_d    = dout_q;
      size_d    = size_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      new_pulse = 1'b0;
      new_len   = 32'd0;
      case (state_q)
         IDLE: if (rec_en && !rec_en_q) begin
            size_d  = '0;
            addr_d  = '0;
            ovf_d   = 1'b0;
            presc_d = '0;
            level_d = mic_in;
            state_d = ARM;
         end
         ARM: if (!rec_en) begin
            state_d = FLUSH;
         end else if (edge_seen) begin
            level_d = mic_in;
            cnt_d   = 32'd0;
            presc_d = '0;
            state_d = REC;
         end
         REC: if (!rec_en) begin
            // The pulse still in progress becomes the final one.
            new_pulse = 1'b1;
            new_len   = (cnt_q == 32'd0) ? 32'd1 : cnt_q;
            state_d   = FLUSH;
         end else if (edge_seen) begin
            // A wrap on the edge cycle still counts toward this pulse.
            new_pulse = 1'b1;
            new_len   = (cnt_inc == 32'd0) ? 32'd1 : cnt_inc;
            level_d   = mic_in;
            cnt_d     = 32'd0;
            presc_d   = '0;
         end else if (ce) begin
            presc_d = wrap ? '0 : presc_q + PW'(1);
            cnt_d   = cnt_inc;
         end
         FLUSH: if (!pend_v_q && !enc_v_q && fifo_empty && !wr_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (push) begin
         enc_idx_d = enc_idx_q + 3'd1;
         wp_d      = wp_q + 1'b1;
         if (enc_last) enc_v_d = 1'b0;
      end
      if (enc_load) begin
         enc_v_d   = 1'b1;
         enc_val_d = pend_q;
         enc_idx_d = 3'd0;
         pend_v_d  = 1'b0;
      end
      // Pending counts as free when it is being handed to the encoder this cycle.
      if (new_pulse) begin
         if (pend_v_q && !enc_load) begin
            ovf_d = 1'b1;
         end else begin
            pend_v_d = 1'b1;
            pend_d   = new_len;
         end
      end
      if (ack) begin
         wr_d   = 1'b0;
         addr_d = addr_q + 1'b1;
         size_d = addr_q + 1'b1;
      end
      // Once the buffer is full, bytes are still popped so FLUSH can finish.
      if (pop) begin
         rp_d = rp_q + 1'b1;
         if (addr_q == max_size) begin
            ovf_d = 1'b1;
         end else begin
            wr_d   = 1'b1;
            dout_d = mem_q[rp_q[FW-1:0]];
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) mem_q[wp_q[FW-1:0]] <= enc_byte;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rec_en_q  <= 1'b0;
         level_q   <= 1'b0;
         presc_q   <= '0;
         cnt_q     <= 32'd0;
         pend_v_q  <= 1'b0;
         pend_q    <= 32'd0;
         enc_v_q   <= 1'b0;
         enc_val_q <= 32'd0;
         enc_idx_q <= 3'd0;
         wp_q      <= '0;
         rp_q      <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         dout_q    <= 8'd0;
         size_q    <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rec_en_q  <= rec_en;
         level_q   <= level_d;
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         pend_v_q  <= pend_v_d;
         pend_q    <= pend_d;
         enc_v_q   <= enc_v_d;
         enc_val_q <= enc_val_d;
         enc_idx_q <= enc_idx_d;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         dout_q    <= dout_d;
         size_q    <= size_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end
endmodule
